// File: rtl/tv80_bus_pkg.sv
// Shared types and helpers for the TV80 bus target: FSM encoding, idle bus value, window decode.
package tv80_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } bus_state_t;

  localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

  // A zero mask disables the window entirely rather than matching everything.
  function automatic logic addr_hit(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input logic [15:0] mask);
    return (mask != 16'h0000) && ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/tv80_addr_decode.sv
// Combinational window decode of TV80 pin strobes into a single-strobe select for the target FSM.
module tv80_addr_decode
  import tv80_bus_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = 16'h8000,
  parameter logic [15:0] MEM_MASK = 16'hC000,
  parameter logic [7:0]  IO_BASE  = 8'h40,
  parameter logic [7:0]  IO_MASK  = 8'hF0
) (
  input  logic [15:0] A,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  output logic        sel,
  output logic        sel_io,
  output logic        intack
);

  logic mem_hit;
  logic io_hit;
  logic one_strobe;
  logic mem_cyc;
  logic io_cyc;

  assign mem_hit    = addr_hit(A, MEM_BASE, MEM_MASK);
  assign io_hit     = addr_hit({8'h00, A[7:0]}, {8'h00, IO_BASE}, {8'h00, IO_MASK});
  // Refresh (no strobe) and the illegal both-strobes case never select.
  assign one_strobe = ~rd_n ^ ~wr_n;
  assign mem_cyc    = ~mreq_n & mem_hit;
  assign io_cyc     = ~iorq_n & m1_n & io_hit;
  assign sel        = (mem_cyc | io_cyc) & one_strobe;
  assign sel_io     = io_cyc;
  assign intack     = ~m1_n & ~iorq_n;

endmodule

// File: rtl/tv80_bus_target.sv
// TV80 bus target: turns CPU strobes into a req/ack backend access, stretching with wait_n.
// Optional interrupt-acknowledge support is enabled with `define TV80_TARGET_INTACK_EN.
//   state   | meaning
//   IDLE    | no access; decode strobes, capture on select
//   REQ     | be_req high, CPU held in wait, timeout timer running
//   DONE    | backend finished; return data until strobes release
module tv80_bus_target
  import tv80_bus_pkg::*;
#(
  parameter logic [15:0] MEM_BASE = 16'h8000,
  parameter logic [15:0] MEM_MASK = 16'hC000,
  parameter logic [7:0]  IO_BASE  = 8'h40,
  parameter logic [7:0]  IO_MASK  = 8'hF0,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  output logic        int_n,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic        be_ack,
  input  logic [7:0]  be_rdata,
  output logic        be_err,
  input  logic        irq,
  input  logic [7:0]  irq_vec
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = '1;

  bus_state_t    state_q;
  bus_state_t    state_d;
  logic [TW-1:0] timer_q;
  logic [7:0]    data_q;
  logic          sel;
  logic          sel_io;
  logic          intack;
  logic          strobe_idle;
  logic          timeout_hit;
  logic          intack_active;
  logic [7:0]    vec_now;

  tv80_addr_decode #(
    .MEM_BASE (MEM_BASE),
    .MEM_MASK (MEM_MASK),
    .IO_BASE  (IO_BASE),
    .IO_MASK  (IO_MASK)
  ) u_decode (
    .A      (A),
    .mreq_n (mreq_n),
    .iorq_n (iorq_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .m1_n   (m1_n),
    .sel    (sel),
    .sel_io (sel_io),
    .intack (intack)
  );

  assign strobe_idle = rd_n & wr_n;
  assign be_req      = (state_q == ST_REQ);

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: if (sel) state_d = ST_REQ;
      ST_REQ: begin
        // CPU abandoning the cycle beats everything; an ack beats a same-cycle timeout.
        if (strobe_idle)               state_d = ST_IDLE;
        else if (be_ack)               state_d = ST_DONE;
        else if (timer_q == T_LAST) begin
          state_d     = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_DONE: if (strobe_idle) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_n = 1'b1;
    cpu_di = BUS_IDLE_DATA;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          wait_n = ~sel;
          if (intack_active) cpu_di = vec_now;
        end
        ST_REQ:  wait_n = 1'b0;
        ST_DONE: if (~rd_n & ~be_we) cpu_di = data_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      data_q   <= 8'h00;
      be_we    <= 1'b0;
      be_io    <= 1'b0;
      be_addr  <= 16'h0000;
      be_wdata <= 8'h00;
      be_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      be_err  <= timeout_hit;
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (sel) begin
            be_addr  <= sel_io ? {8'h00, A[7:0]} : A;
            be_wdata <= cpu_do;
            be_we    <= ~wr_n;
            be_io    <= sel_io;
          end
        end
        ST_REQ: begin
          if (timer_q != T_MAX) timer_q <= timer_q + 1'b1;
          if (be_ack & ~strobe_idle) data_q <= be_rdata;
          else if (timeout_hit)      data_q <= BUS_IDLE_DATA;
        end
        default: ;
      endcase
    end
  end

`ifdef TV80_TARGET_INTACK_EN
  logic       int_n_q;
  logic       intack_q;
  logic [7:0] vec_q;
  logic       intack_start;

  assign intack_start = intack & ~intack_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      int_n_q  <= 1'b1;
      intack_q <= 1'b0;
      vec_q    <= 8'h00;
    end else begin
      int_n_q  <= ~irq;
      intack_q <= intack;
      if (intack_start) vec_q <= irq_vec;
    end
  end

  // Vector is frozen at the first intack cycle so a changing irq_vec cannot glitch the read.
  assign int_n         = int_n_q;
  assign intack_active = intack & ~int_n_q;
  assign vec_now       = intack_start ? irq_vec : vec_q;
`else
  logic unused_intack;
  assign unused_intack = ^{irq, irq_vec, intack};
  assign int_n         = 1'b1;
  assign intack_active = 1'b0;
  assign vec_now       = BUS_IDLE_DATA;
`endif

endmodule

// File: tb/tb_tv80_bus_target.sv
// Directed self-checking bench for tv80_bus_target with default window and timeout parameters.
module tb_tv80_bus_target;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  cpu_do = 8'h00;
  logic        mreq_n = 1'b1;
  logic        iorq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        m1_n = 1'b1;
  logic [7:0]  cpu_di;
  logic        wait_n;
  logic        int_n;
  logic        be_req;
  logic        be_we;
  logic        be_io;
  logic [15:0] be_addr;
  logic [7:0]  be_wdata;
  logic        be_ack = 1'b0;
  logic [7:0]  be_rdata = 8'h00;
  logic        be_err;
  logic        irq = 1'b0;
  logic [7:0]  irq_vec = 8'h00;

  int checks = 0;
  int fails = 0;

`ifdef TV80_TARGET_INTACK_EN
  localparam logic       INT_LOW = 1'b0;
  localparam logic [7:0] VEC_EXP = 8'hE0;
`else
  localparam logic       INT_LOW = 1'b1;
  localparam logic [7:0] VEC_EXP = 8'hFF;
`endif

  tv80_bus_target dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .cpu_do   (cpu_do),
    .mreq_n   (mreq_n),
    .iorq_n   (iorq_n),
    .rd_n     (rd_n),
    .wr_n     (wr_n),
    .m1_n     (m1_n),
    .cpu_di   (cpu_di),
    .wait_n   (wait_n),
    .int_n    (int_n),
    .be_req   (be_req),
    .be_we    (be_we),
    .be_io    (be_io),
    .be_addr  (be_addr),
    .be_wdata (be_wdata),
    .be_ack   (be_ack),
    .be_rdata (be_rdata),
    .be_err   (be_err),
    .irq      (irq),
    .irq_vec  (irq_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic release_bus();
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    m1_n   = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_be_req", 32'(be_req), 0);
    chk("rst_be_err", 32'(be_err), 0);
    chk("rst_wait_n", 32'(wait_n), 1);
    chk("rst_int_n", 32'(int_n), 1);
    chk("rst_cpu_di", 32'(cpu_di), 'hFF);
    chk("rst_be_addr", 32'(be_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    // Memory read at 8123, ack on third REQ cycle
    A = 16'h8123; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    chk("mrd_wait_idle", 32'(wait_n), 0);
    chk("mrd_req_idle", 32'(be_req), 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("mrd_req", 32'(be_req), 1);
      chk("mrd_wait", 32'(wait_n), 0);
      if (i == 1) begin
        chk("mrd_addr", 32'(be_addr), 'h8123);
        chk("mrd_we", 32'(be_we), 0);
        chk("mrd_io", 32'(be_io), 0);
      end
      if (i == 3) begin
        be_ack = 1'b1; be_rdata = 8'h5A;
      end
    end
    @(negedge clk);
    be_ack = 1'b0;
    #1;
    chk("mrd_req_done", 32'(be_req), 0);
    chk("mrd_wait_done", 32'(wait_n), 1);
    chk("mrd_data", 32'(cpu_di), 'h5A);
    chk("mrd_err", 32'(be_err), 0);
    release_bus();
    @(negedge clk);
    chk("mrd_di_after", 32'(cpu_di), 'hFF);
    chk("mrd_req_after", 32'(be_req), 0);

    // I/O write at AB42: upper address byte must be zeroed
    A = 16'hAB42; cpu_do = 8'hC3; iorq_n = 1'b0; wr_n = 1'b0;
    #1;
    chk("iow_wait_idle", 32'(wait_n), 0);
    @(negedge clk);
    chk("iow_req", 32'(be_req), 1);
    chk("iow_io", 32'(be_io), 1);
    chk("iow_we", 32'(be_we), 1);
    chk("iow_addr", 32'(be_addr), 'h0042);
    chk("iow_wdata", 32'(be_wdata), 'hC3);
    be_ack = 1'b1; be_rdata = 8'h00;
    @(negedge clk);
    be_ack = 1'b0;
    chk("iow_req_done", 32'(be_req), 0);
    chk("iow_wait_done", 32'(wait_n), 1);
    release_bus();
    @(negedge clk);

    // Miss, refresh, and both strobes low are all ignored
    A = 16'h1000; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    chk("miss_wait", 32'(wait_n), 1);
    chk("miss_di", 32'(cpu_di), 'hFF);
    @(negedge clk);
    chk("miss_req", 32'(be_req), 0);
    A = 16'h8000; rd_n = 1'b1;
    #1;
    chk("rfsh_wait", 32'(wait_n), 1);
    @(negedge clk);
    chk("rfsh_req", 32'(be_req), 0);
    rd_n = 1'b0; wr_n = 1'b0;
    #1;
    chk("both_wait", 32'(wait_n), 1);
    @(negedge clk);
    chk("both_req", 32'(be_req), 0);
    release_bus();
    @(negedge clk);

    // Timeout: no ack for 16 REQ cycles
    A = 16'h8010; mreq_n = 1'b0; rd_n = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("tmo_req", 32'(be_req), 1);
      chk("tmo_err_early", 32'(be_err), 0);
    end
    @(negedge clk);
    chk("tmo_req_off", 32'(be_req), 0);
    chk("tmo_err", 32'(be_err), 1);
    chk("tmo_wait", 32'(wait_n), 1);
    chk("tmo_di", 32'(cpu_di), 'hFF);
    be_ack = 1'b1; be_rdata = 8'h77;
    @(negedge clk);
    be_ack = 1'b0;
    chk("tmo_err_pulse", 32'(be_err), 0);
    chk("late_ack_di", 32'(cpu_di), 'hFF);
    release_bus();
    @(negedge clk);

    // Next access after timeout: I/O read at 45
    A = 16'h0045; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    chk("ior_req", 32'(be_req), 1);
    chk("ior_addr", 32'(be_addr), 'h0045);
    be_ack = 1'b1; be_rdata = 8'h3C;
    @(negedge clk);
    be_ack = 1'b0;
    chk("ior_di", 32'(cpu_di), 'h3C);
    release_bus();
    @(negedge clk);

    // Ack on the same cycle the timer expires: ack wins
    A = 16'hBFFF; mreq_n = 1'b0; rd_n = 1'b0;
    repeat (16) @(negedge clk);
    chk("race_req", 32'(be_req), 1);
    be_ack = 1'b1; be_rdata = 8'hA5;
    @(negedge clk);
    be_ack = 1'b0;
    chk("race_err", 32'(be_err), 0);
    chk("race_di", 32'(cpu_di), 'hA5);
    release_bus();
    @(negedge clk);

    // Strobe released during REQ
    A = 16'h8200; cpu_do = 8'h11; mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    chk("abort_req", 32'(be_req), 1);
    release_bus();
    @(negedge clk);
    chk("abort_req_off", 32'(be_req), 0);
    chk("abort_err", 32'(be_err), 0);
    chk("abort_wait", 32'(wait_n), 1);
    @(negedge clk);
    chk("abort_err2", 32'(be_err), 0);

    // Reset in REQ, then a late ack
    A = 16'h8300; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    chk("rstreq_req", 32'(be_req), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstreq_req_off", 32'(be_req), 0);
    chk("rstreq_wait", 32'(wait_n), 1);
    release_bus();
    reset = 1'b0; be_ack = 1'b1; be_rdata = 8'h99;
    @(negedge clk);
    be_ack = 1'b0;
    chk("rstreq_late_req", 32'(be_req), 0);
    chk("rstreq_late_err", 32'(be_err), 0);
    chk("rstreq_late_di", 32'(cpu_di), 'hFF);

    // Interrupt acknowledge
    irq = 1'b1; irq_vec = 8'hE0;
    @(negedge clk);
    chk("irq_int_n", 32'(int_n), 32'(INT_LOW));
    A = 16'h0040; m1_n = 1'b0; iorq_n = 1'b0;
    #1;
    chk("intack_wait", 32'(wait_n), 1);
    chk("intack_vec", 32'(cpu_di), 32'(VEC_EXP));
    @(negedge clk);
    irq_vec = 8'h11;
    #1;
    chk("intack_req", 32'(be_req), 0);
    chk("intack_vec_held", 32'(cpu_di), 32'(VEC_EXP));
    release_bus();
    irq = 1'b0;
    repeat (2) @(negedge clk);
    chk("irq_clear", 32'(int_n), 1);
    chk("idle_di", 32'(cpu_di), 'hFF);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
